// File: rtl/axis_lrelu_config_injector.sv
// axis_lrelu_config_injector
//   Merges per-iteration config beats and conv-engine data beats into one AXI-Stream
//   for the LReLU engine. Each iteration is emitted as config beats (CFG_BEATS_1X1 or
//   CFG_BEATS_3X3 of them, selected by kernel_h-1 in the first config beat's tuser)
//   followed by data beats up to and including the data beat carrying tlast.
//   The output goes through a 2-entry skid buffer (output reg + skid reg).
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   s_data_*                      conv-engine data stream (tvalid/tready/tdata/tkeep/tuser/tlast)
//   s_cfg_*                       config stream (tvalid/tready/tdata/tuser/tlast)
//   m_axis_*                      merged stream to the LReLU engine
//   debug_state                   current FSM state (0 CFG_1, 1 CFG_N, 2 PASS)
//   err_cfg_len                   sticky config-length error
// Build option
//   AXIS_LRELU_INJ_CHECK_EN       enables the s_cfg_tlast length check driving err_cfg_len;
//                                 when undefined err_cfg_len is 0 and s_cfg_tlast is ignored.
module axis_lrelu_config_injector #(
    parameter int unsigned TDATA_W       = 8192,
    parameter int unsigned TKEEP_W       = 1024,
    parameter int unsigned TUSER_W       = 64,
    parameter int unsigned I_KERNEL_H_1  = 0,
    parameter int unsigned BITS_KERNEL_H = 2,
    parameter int unsigned CFG_BEATS_1X1 = 2,
    parameter int unsigned CFG_BEATS_3X3 = 10
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_data_tvalid,
    output logic               s_data_tready,
    input  logic [TDATA_W-1:0] s_data_tdata,
    input  logic [TKEEP_W-1:0] s_data_tkeep,
    input  logic [TUSER_W-1:0] s_data_tuser,
    input  logic               s_data_tlast,
    input  logic               s_cfg_tvalid,
    output logic               s_cfg_tready,
    input  logic [TDATA_W-1:0] s_cfg_tdata,
    input  logic [TUSER_W-1:0] s_cfg_tuser,
    input  logic               s_cfg_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic [TKEEP_W-1:0] m_axis_tkeep,
    output logic [TUSER_W-1:0] m_axis_tuser,
    output logic               m_axis_tlast,
    output logic [2:0]         debug_state,
    output logic               err_cfg_len
);

    localparam int unsigned MAX_BEATS = (CFG_BEATS_3X3 > CFG_BEATS_1X1) ? CFG_BEATS_3X3 : CFG_BEATS_1X1;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {
        ST_CFG_1 = 3'd0,
        ST_CFG_N = 3'd1,
        ST_PASS  = 3'd2
    } state_t;

    typedef struct packed {
        logic [TDATA_W-1:0] data;
        logic [TKEEP_W-1:0] keep;
        logic [TUSER_W-1:0] user;
        logic               last;
    } beat_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    beat_t                    out_q, out_d, skid_q, skid_d;
    logic                     out_valid_q, out_valid_d;
    logic                     skid_valid_q, skid_valid_d;

    logic                     rdy;
    logic                     cfg_fire, data_fire, in_fire;
    logic [BITS_KERNEL_H-1:0] kh1;
    logic [CNT_W-1:0]         first_cnt;
    beat_t                    in_beat;

    // Registered ready: accept only while the skid slot is free
    assign rdy           = !skid_valid_q;
    assign s_cfg_tready  = !areset && rdy && (state_q != ST_PASS);
    assign s_data_tready = !areset && rdy && (state_q == ST_PASS);
    assign cfg_fire      = s_cfg_tvalid && s_cfg_tready;
    assign data_fire     = s_data_tvalid && s_data_tready;
    assign in_fire       = cfg_fire || data_fire;

    assign kh1       = s_cfg_tuser[I_KERNEL_H_1 +: BITS_KERNEL_H];
    assign first_cnt = (kh1 == '0) ? CNT_W'(CFG_BEATS_1X1 - 1) : CNT_W'(CFG_BEATS_3X3 - 1);

    // Source mux: config beats go out with full keep and no tlast
    always_comb begin
        in_beat = '0;
        if (state_q == ST_PASS) begin
            in_beat.data = s_data_tdata;
            in_beat.keep = s_data_tkeep;
            in_beat.user = s_data_tuser;
            in_beat.last = s_data_tlast;
        end else begin
            in_beat.data = s_cfg_tdata;
            in_beat.keep = '1;
            in_beat.user = s_cfg_tuser;
            in_beat.last = 1'b0;
        end
    end

    // Next state: sequencing FSM, length check and skid buffer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        case (state_q)
            ST_CFG_1: begin
                if (cfg_fire) begin
                    cnt_d   = first_cnt;
                    state_d = (first_cnt == '0) ? ST_PASS : ST_CFG_N;
                end
            end
            ST_CFG_N: begin
                if (cfg_fire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                if (data_fire && s_data_tlast) begin
                    state_d = ST_CFG_1;
                end
            end
            default: state_d = ST_CFG_1;
        endcase

`ifdef AXIS_LRELU_INJ_CHECK_EN
        // tlast must appear exactly on the final config beat of the iteration
        if (cfg_fire) begin
            if (state_q == ST_CFG_1) begin
                if (s_cfg_tlast != (first_cnt == '0)) begin
                    err_d = 1'b1;
                end
            end else if (s_cfg_tlast != (cnt_q == CNT_W'(1))) begin
                err_d = 1'b1;
            end
        end
`endif

        // Output slot refills from skid first; input only lands in skid when output stalls
        if (!out_valid_q || m_axis_tready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = in_beat;
                end
            end
        end else if (in_fire) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

`ifndef AXIS_LRELU_INJ_CHECK_EN
    logic unused_cfg_tlast;
    assign unused_cfg_tlast = s_cfg_tlast;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_CFG_1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tlast  = out_q.last;
    assign debug_state   = state_q;
    assign err_cfg_len   = err_q;

endmodule

// File: tb/tb_axis_lrelu_config_injector.sv
// Testbench for axis_lrelu_config_injector: randomized traffic against a stream-order
// reference model (config beats of each iteration, then its data beats).
module tb_axis_lrelu_config_injector;

    localparam int unsigned DW  = 64;
    localparam int unsigned KW  = 8;
    localparam int unsigned UW  = 16;
    localparam int unsigned KHL = 0;
    localparam int unsigned KHW = 2;

`ifdef AXIS_LRELU_INJ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          aclk, areset;
    logic          s_data_tvalid, s_data_tready, s_data_tlast;
    logic [DW-1:0] s_data_tdata;
    logic [KW-1:0] s_data_tkeep;
    logic [UW-1:0] s_data_tuser;
    logic          s_cfg_tvalid, s_cfg_tready, s_cfg_tlast;
    logic [DW-1:0] s_cfg_tdata;
    logic [UW-1:0] s_cfg_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic [2:0]    debug_state;
    logic          err_cfg_len;

    axis_lrelu_config_injector #(
        .TDATA_W(DW), .TKEEP_W(KW), .TUSER_W(UW),
        .I_KERNEL_H_1(KHL), .BITS_KERNEL_H(KHW),
        .CFG_BEATS_1X1(2), .CFG_BEATS_3X3(10)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep),
        .s_data_tuser(s_data_tuser), .s_data_tlast(s_data_tlast),
        .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
        .s_cfg_tdata(s_cfg_tdata), .s_cfg_tuser(s_cfg_tuser), .s_cfg_tlast(s_cfg_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .debug_state(debug_state), .err_cfg_len(err_cfg_len)
    );

    beat_t cfg_src_q[$];
    beat_t data_src_q[$];
    beat_t exp_q[$];
    int    iter_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    bit in_cfg  = 1'b1;
    int cfg_left = 0;
    int tready_mode = 0;
    bit gaps = 1'b0;
    int data_fired = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Scoreboard and phase check, sampled mid-cycle
    always @(negedge aclk) begin : mon
        beat_t e;
        beat_t got;
        if (!areset) begin
            n_tests++;
            if ((in_cfg && s_data_tready) || (!in_cfg && s_cfg_tready)) begin
                n_fail++;
                $display("FAIL phase_ready: in_cfg=%0b s_cfg_tready=%0b s_data_tready=%0b (only the phase source may be ready)",
                         in_cfg, s_cfg_tready, s_data_tready);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                n_tests++;
                got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: got %h, required no beat", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL out_beat: got %h required %h", got, e);
                    end
                end
            end
        end
    end

    task automatic add_iter(input int kh1, input int ndata, input bit bad_tlast);
        int    n;
        beat_t b;
        n = (kh1 == 0) ? 2 : 10;
        iter_q.push_back(n);
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = '0;
            b.user = UW'($urandom);
            if (i == 0) b.user[KHL +: KHW] = KHW'(kh1);
            b.last = bad_tlast ? (i == 0) : (i == n - 1);
            cfg_src_q.push_back(b);
            b.keep = '1;
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < ndata; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (i == ndata - 1);
            data_src_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_src(input bit cf, input bit df);
        if (cf || !s_cfg_tvalid) begin
            s_cfg_tvalid = (cfg_src_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
            if (cfg_src_q.size() > 0) begin
                s_cfg_tdata = cfg_src_q[0].data;
                s_cfg_tuser = cfg_src_q[0].user;
                s_cfg_tlast = cfg_src_q[0].last;
            end
        end
        if (df || !s_data_tvalid) begin
            s_data_tvalid = (data_src_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
            if (data_src_q.size() > 0) begin
                s_data_tdata = data_src_q[0].data;
                s_data_tkeep = data_src_q[0].keep;
                s_data_tuser = data_src_q[0].user;
                s_data_tlast = data_src_q[0].last;
            end
        end
    endtask

    task automatic set_tready();
        case (tready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic run_traffic(input int max_cycles, input int abort_after);
        int    cyc;
        bit    cf, df;
        beat_t b;
        cyc = 0;
        data_fired = 0;
        set_src(1'b0, 1'b0);
        set_tready();
        while (cyc < max_cycles &&
               !(cfg_src_q.size() == 0 && data_src_q.size() == 0 && exp_q.size() == 0) &&
               !(abort_after > 0 && data_fired >= abort_after)) begin
            @(negedge aclk);
            cf = s_cfg_tvalid && s_cfg_tready;
            df = s_data_tvalid && s_data_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (cf) begin
                void'(cfg_src_q.pop_front());
                if (cfg_left == 0) cfg_left = iter_q.pop_front() - 1;
                else cfg_left--;
                if (cfg_left == 0) in_cfg = 1'b0;
            end
            if (df) begin
                b = data_src_q.pop_front();
                data_fired++;
                if (b.last) in_cfg = 1'b1;
            end
            set_src(cf, df);
            set_tready();
        end
        if (cyc >= max_cycles) begin
            n_tests++;
            n_fail++;
            $display("FAIL traffic_timeout: %0d beats still expected after %0d cycles, required 0", exp_q.size(), cyc);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_cfg_tvalid = 1'b0;
        s_data_tvalid = 1'b0;
        cfg_src_q.delete();
        data_src_q.delete();
        exp_q.delete();
        iter_q.delete();
        in_cfg = 1'b1;
        cfg_left = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        s_cfg_tvalid = 1'b1;
        s_data_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_tests++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: tvalid=%0b tdata=%h tkeep=%h tuser=%h tlast=%0b, required all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast);
        end
        n_tests++;
        if ({s_cfg_tready, s_data_tready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_tready: cfg=%0b data=%0b, required 0 0", s_cfg_tready, s_data_tready);
        end
        n_tests++;
        if ({debug_state, err_cfg_len} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d err=%0b, required 0 0", debug_state, err_cfg_len);
        end
        do_reset();
    endtask

    task automatic test_cfg_1x1();
        int n0;
        tready_mode = 0;
        gaps = 1'b0;
        n0 = n_out;
        add_iter(0, 4, 1'b0);
        run_traffic(200, 0);
        n_tests++;
        if (n_out - n0 !== 6) begin
            n_fail++;
            $display("FAIL cfg1x1_count: %0d beats out, required 6", n_out - n0);
        end
        n_tests++;
        if (debug_state !== 3'd0 || err_cfg_len !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg1x1_end: state=%0d err=%0b, required 0 0", debug_state, err_cfg_len);
        end
    endtask

    task automatic test_cfg_3x3();
        int n0;
        int nd;
        tready_mode = 0;
        gaps = 1'b0;
        n0 = n_out;
        add_iter(2, 5, 1'b0);
        run_traffic(300, 0);
        n_tests++;
        if (n_out - n0 !== 15) begin
            n_fail++;
            $display("FAIL cfg3x3_count: %0d beats out, required 15", n_out - n0);
        end
        for (int k = 1; k <= 3; k++) begin
            nd = int'($urandom_range(1, 6));
            n0 = n_out;
            add_iter(k, nd, 1'b0);
            run_traffic(300, 0);
            n_tests++;
            if (n_out - n0 !== 10 + nd) begin
                n_fail++;
                $display("FAIL cfg3x3_kh%0d_count: %0d beats out, required %0d", k, n_out - n0, 10 + nd);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        int tot;
        tready_mode = 1;
        gaps = 1'b0;
        n0 = n_out;
        add_iter(0, 4, 1'b0);
        run_traffic(300, 0);
        n_tests++;
        if (n_out - n0 !== 6) begin
            n_fail++;
            $display("FAIL bp_toggle_count: %0d beats out, required 6", n_out - n0);
        end
        tready_mode = 2;
        gaps = 1'b1;
        n0 = n_out;
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            int kh;
            int nd;
            kh = int'($urandom_range(0, 3));
            nd = int'($urandom_range(1, 8));
            add_iter(kh, nd, 1'b0);
            tot += ((kh == 0) ? 2 : 10) + nd;
        end
        run_traffic(2000, 0);
        n_tests++;
        if (n_out - n0 !== tot) begin
            n_fail++;
            $display("FAIL bp_random_count: %0d beats out, required %0d", n_out - n0, tot);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        tready_mode = 0;
        gaps = 1'b0;
        n0 = n_out;
        add_iter(0, 3, 1'b0);
        add_iter(1, 2, 1'b0);
        add_iter(0, 1, 1'b0);
        run_traffic(500, 0);
        n_tests++;
        if (n_out - n0 !== 20) begin
            n_fail++;
            $display("FAIL b2b_count: %0d beats out, required 20", n_out - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        tready_mode = 0;
        gaps = 1'b0;
        add_iter(0, 4, 1'b0);
        run_traffic(200, 2);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || debug_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid: tvalid=%0b state=%0d, required 0 0", m_axis_tvalid, debug_state);
        end
        do_reset();
        n0 = n_out;
        add_iter(0, 4, 1'b0);
        run_traffic(200, 0);
        n_tests++;
        if (n_out - n0 !== 6 || debug_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: %0d beats out state=%0d, required 6 0", n_out - n0, debug_state);
        end
    endtask

    task automatic test_cfg_len_err();
        tready_mode = 0;
        gaps = 1'b0;
        add_iter(0, 3, 1'b1);
        run_traffic(200, 0);
        n_tests++;
        if (err_cfg_len !== EXP_ERR) begin
            n_fail++;
            $display("FAIL cfg_len_err: err=%0b, required %0b", err_cfg_len, EXP_ERR);
        end
        add_iter(0, 3, 1'b0);
        run_traffic(200, 0);
        n_tests++;
        if (err_cfg_len !== EXP_ERR) begin
            n_fail++;
            $display("FAIL cfg_len_err_hold: err=%0b, required %0b", err_cfg_len, EXP_ERR);
        end
        do_reset();
        @(negedge aclk);
        n_tests++;
        if (err_cfg_len !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_len_err_clear: err=%0b, required 0", err_cfg_len);
        end
    endtask

    initial begin
        areset = 1'b1;
        s_cfg_tvalid = 1'b0; s_cfg_tdata = '0; s_cfg_tuser = '0; s_cfg_tlast = 1'b0;
        s_data_tvalid = 1'b0; s_data_tdata = '0; s_data_tkeep = '0; s_data_tuser = '0; s_data_tlast = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_cfg_1x1();
        test_cfg_3x3();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_cfg_len_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
